axi_burst_checker: RTL and testbench
====================================

Name: axi_burst_checker

Overview:
- Parametrised AXI4 master traffic generator and checker; successor to the single-shot example master behind the ProtectionUnit.
- On an init pulse it writes C_NUM_BURSTS INCR bursts of C_BURST_LEN beats to a target window.
- It then reads every burst back and compares each beat against the regenerated pattern.
- Reports completion and a sticky error.
- Used in the ProtectionUnit BFM design to load the slave path from a hardware master alongside the VIP masters.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; one of 32/64/128.
- C_BURST_LEN, 8, beats per burst; 1..256.
- C_NUM_BURSTS, 4, bursts per pass; 1..1024.
- C_TARGET_BASE, 32'h0000_0000, base byte address of the window. Must be burst-aligned; no burst may cross 4 KB.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  start request; rising edge detected internally.
- TXN_DONE  out  1  pass complete; held high until the next accepted start.
- ERROR  out  1  sticky mismatch or bad response.
- ERR_COUNT  out  16  count of failing beats plus failing responses; saturating.
- M_AXI_AW*  AWADDR out ADDR_W, AWLEN out 8, AWVALID out 1, AWREADY in 1.
- M_AXI_W*  WDATA out DATA_W, WSTRB out DATA_W/8, WLAST out 1, WVALID out 1, WREADY in 1.
- M_AXI_B*  BRESP in 2, BVALID in 1, BREADY out 1.
- M_AXI_AR*  ARADDR out ADDR_W, ARLEN out 8, ARVALID out 1, ARREADY in 1.
- M_AXI_R*  RDATA in DATA_W, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
- Constant outputs: AWID/ARID=0, AxSIZE=clog2(DATA_W/8), AxBURST=INCR, AxLOCK=0, AxCACHE=4'b0011, AxPROT=0, AxQOS=0, WSTRB all ones.

Behaviour:
- Reset (ARESETN low, async): FSM=IDLE. All VALID and READY outputs 0, TXN_DONE=0, ERROR=0, ERR_COUNT=0, counters 0. Reset mid-burst abandons the transfer immediately; no drain.
- Start: a rising edge of INIT_AXI_TXN, registered, is accepted only in IDLE or DONE. It clears TXN_DONE, ERROR and ERR_COUNT and enters WR_ADDR. Edges in any other state are ignored.
- Address of burst n = C_TARGET_BASE + n*C_BURST_LEN*(DATA_W/8). AxLEN = C_BURST_LEN-1.
- WR_ADDR: AWVALID=1 and held stable until AWREADY; then WR_DATA.
- WR_DATA: WVALID=1. A beat transfers on WVALID&WREADY. WLAST is high on beat C_BURST_LEN-1. After the last beat, WVALID drops the next cycle and the FSM goes to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, BRESP!=OKAY increments ERR_COUNT and sets ERROR. Next state is WR_ADDR for the next burst, or RD_ADDR after burst C_NUM_BURSTS-1.
- Outstanding transactions: one only; no AW/W overlap; AW always precedes W.
- RD_ADDR: ARVALID until ARREADY; then RD_DATA.
- RD_DATA: RREADY=1. Each RVALID beat is compared with the expected pattern; a mismatch or RRESP!=OKAY increments ERR_COUNT once for that beat.
  - RLAST on a beat other than C_BURST_LEN-1, or missing on that beat, counts one error.
  - The burst ends on beat count, not on RLAST.
  - After the last read burst the FSM goes to DONE.
- DONE: TXN_DONE=1, ERROR holds, stays here until the next start.
- Pattern: global beat index k (0..C_NUM_BURSTS*C_BURST_LEN-1) gives data = k+1, zero-extended to DATA_W.
- ERR_COUNT saturates at 16'hFFFF. ERROR = (ERR_COUNT != 0), registered.
- Address and beat counters are sized clog2(C_NUM_BURSTS) and clog2(C_BURST_LEN)+1; no wrap within a pass.
- Simultaneous B/R handshake with start edge: impossible by construction (start ignored while busy).

Optional Feature:
- Macro AXI_BURST_CHECKER_LFSR_EN.
- Defined: data comes from a 32-bit Galois LFSR (taps 32,22,2,1, seed 32'hACE1_0001), replicated across DATA_W. The LFSR advances once per W beat. It is reseeded at the start of the read phase and advances once per R beat, so expected data regenerates identically.
- Undefined: incrementing k+1 pattern, no LFSR logic.

Test Plan:
- Defaults, AXI VIP slave memory, INIT pulse 20 ns after reset release -> 4 AW at 0x00/0x20/0x40/0x60, write data 1..32, 4 AR, TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- Slave returns BRESP=SLVERR on burst 2 -> ERROR=1, ERR_COUNT=1, read phase still completes, TXN_DONE=1.
- Backdoor-corrupt memory word at 0x44 before readback -> ERR_COUNT=1, ERROR=1.
- Random AWREADY/WREADY/ARREADY/RVALID backpressure (50%) -> AWADDR/WDATA stable while VALID&!READY, results identical to the first scenario.
- ARESETN low during WR_DATA beat 3, then a new INIT -> all VALIDs 0 during reset, clean full pass afterwards with ERROR=0.
- C_BURST_LEN=1, C_NUM_BURSTS=1, DATA_W=64, second INIT after DONE -> WLAST on the only beat, data 64'h1, TXN_DONE cleared then re-asserted, ERR_COUNT=0.

Source files
------------

// File: rtl/axi_burst_checker.sv
// AXI4 master that writes C_NUM_BURSTS INCR bursts, reads them back and checks every beat.
// Define AXI_BURST_CHECKER_LFSR_EN to use a 32-bit Galois LFSR data pattern instead of k+1.
module axi_burst_checker #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BURST_LEN        = 8,
    parameter int unsigned C_NUM_BURSTS       = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [15:0]                     ERR_COUNT,
    output logic [0:0]                      M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [0:0]                      M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);
    localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW     = C_M_AXI_DATA_WIDTH;
    localparam int unsigned BurstW = (C_NUM_BURSTS > 1) ? $clog2(C_NUM_BURSTS) : 1;
    localparam int unsigned BeatW  = $clog2(C_BURST_LEN) + 1;

    localparam logic [AW-1:0]     BurstBytes = AW'(C_BURST_LEN * (DW / 8));
    localparam logic [BeatW-1:0]  LastBeat   = BeatW'(C_BURST_LEN - 1);
    localparam logic [BurstW-1:0] LastBurst  = BurstW'(C_NUM_BURSTS - 1);
    localparam logic [7:0]        AxLen      = 8'(C_BURST_LEN - 1);
    localparam logic [2:0]        AxSize     = 3'($clog2(DW / 8));

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
    } state_e;

    state_e              state_q;
    logic [1:0]          init_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                done_q, error_q;
    logic [15:0]         err_q, err_d;
    logic [BurstW-1:0]   burst_q;
    logic [BeatW-1:0]    beat_q;
    logic [31:0]         pat_q, pat_next;
    logic [DW-1:0]       pat_data;
    logic [AW-1:0]       burst_addr;
    logic                start, last_beat, last_burst, beat_bad, rlast_bad;
    logic [1:0]          err_inc;
    logic [16:0]         err_sum;

`ifdef AXI_BURST_CHECKER_LFSR_EN
    localparam logic [31:0] PatSeed = 32'hACE1_0001;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    always_comb pat_next = {1'b0, pat_q[31:1]} ^ (pat_q[0] ? 32'h8020_0003 : 32'h0);
    always_comb pat_data = {(DW / 32){pat_q}};
`else
    localparam logic [31:0] PatSeed = 32'd1;
    always_comb pat_next = pat_q + 32'd1;
    always_comb pat_data = DW'(pat_q);
`endif

    assign start      = init_q[0] & ~init_q[1];
    assign last_beat  = (beat_q == LastBeat);
    assign last_burst = (burst_q == LastBurst);
    assign burst_addr = C_TARGET_BASE + AW'(burst_q) * BurstBytes;
    assign beat_bad   = (M_AXI_RDATA != pat_data) || (M_AXI_RRESP != 2'b00);
    assign rlast_bad  = (M_AXI_RLAST != last_beat);

    always_comb begin
        err_inc = 2'd0;
        if (state_q == StWrResp && M_AXI_BVALID && M_AXI_BRESP != 2'b00) begin
            err_inc = 2'd1;
        end
        if (state_q == StRdData && M_AXI_RVALID) begin
            err_inc = {1'b0, beat_bad} + {1'b0, rlast_bad};
        end
        err_sum = {1'b0, err_q} + 17'(err_inc);
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q    <= 2'b00;
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_q     <= 16'd0;
            burst_q   <= '0;
            beat_q    <= '0;
            pat_q     <= PatSeed;
        end else begin
            init_q  <= {init_q[0], INIT_AXI_TXN};
            err_q   <= err_d;
            error_q <= (err_d != 16'd0);
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        err_q     <= 16'd0;
                        error_q   <= 1'b0;
                        done_q    <= 1'b0;
                        burst_q   <= '0;
                        beat_q    <= '0;
                        pat_q     <= PatSeed;
                        awvalid_q <= 1'b1;
                        state_q   <= StWrAddr;
                    end
                end
                StWrAddr: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= StWrData;
                    end
                end
                StWrData: begin
                    if (M_AXI_WREADY) begin
                        pat_q  <= pat_next;
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= StWrResp;
                        end
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        if (last_burst) begin
                            // Restart the pattern so the read phase regenerates the written data.
                            burst_q   <= '0;
                            pat_q     <= PatSeed;
                            arvalid_q <= 1'b1;
                            state_q   <= StRdAddr;
                        end else begin
                            burst_q   <= burst_q + 1'b1;
                            awvalid_q <= 1'b1;
                            state_q   <= StWrAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (M_AXI_RVALID) begin
                        pat_q  <= pat_next;
                        beat_q <= beat_q + 1'b1;
                        // Burst ends on beat count; RLAST is only checked.
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            if (last_burst) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                burst_q   <= burst_q + 1'b1;
                                arvalid_q <= 1'b1;
                                state_q   <= StRdAddr;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_COUNT     = err_q;
    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = burst_addr;
    assign M_AXI_AWLEN   = AxLen;
    assign M_AXI_AWSIZE  = AxSize;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = pat_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wvalid_q & last_beat;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = burst_addr;
    assign M_AXI_ARLEN   = AxLen;
    assign M_AXI_ARSIZE  = AxSize;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_burst_checker.sv
// Bench for axi_burst_checker: memory slave with optional backpressure, fault injection,
// and a pattern/address reference model; a second instance covers the single-beat 64-bit case.
module tb_axi_burst_checker;
    localparam int NB = 4;
    localparam int BL = 8;
    localparam int NBEATS = NB * BL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance 0: default parameters.
    logic        init0, done0, error0;
    logic [15:0] errc0;
    logic [0:0]  awid, arid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_burst_checker dut0 (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init0), .TXN_DONE(done0), .ERROR(error0),
        .ERR_COUNT(errc0),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // Instance 1: one single-beat burst, 64-bit data.
    logic        d1_init, d1_done, d1_error;
    logic [15:0] d1_errc;
    logic [0:0]  d1_awid, d1_arid;
    logic [31:0] d1_awaddr, d1_araddr;
    logic [63:0] d1_wdata, d1_rdata;
    logic [7:0]  d1_awlen, d1_arlen, d1_wstrb;
    logic [2:0]  d1_awsize, d1_arsize, d1_awprot, d1_arprot;
    logic [1:0]  d1_awburst, d1_arburst, d1_bresp, d1_rresp;
    logic        d1_awlock, d1_arlock;
    logic [3:0]  d1_awcache, d1_arcache, d1_awqos, d1_arqos;
    logic        d1_awvalid, d1_awready, d1_wlast, d1_wvalid, d1_wready, d1_bvalid, d1_bready;
    logic        d1_arvalid, d1_arready, d1_rlast, d1_rvalid, d1_rready;

    axi_burst_checker #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(64), .C_BURST_LEN(1), .C_NUM_BURSTS(1),
        .C_TARGET_BASE(32'h0)
    ) dut1 (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(d1_init), .TXN_DONE(d1_done),
        .ERROR(d1_error), .ERR_COUNT(d1_errc),
        .M_AXI_AWID(d1_awid), .M_AXI_AWADDR(d1_awaddr), .M_AXI_AWLEN(d1_awlen),
        .M_AXI_AWSIZE(d1_awsize), .M_AXI_AWBURST(d1_awburst), .M_AXI_AWLOCK(d1_awlock),
        .M_AXI_AWCACHE(d1_awcache), .M_AXI_AWPROT(d1_awprot), .M_AXI_AWQOS(d1_awqos),
        .M_AXI_AWVALID(d1_awvalid), .M_AXI_AWREADY(d1_awready),
        .M_AXI_WDATA(d1_wdata), .M_AXI_WSTRB(d1_wstrb), .M_AXI_WLAST(d1_wlast),
        .M_AXI_WVALID(d1_wvalid), .M_AXI_WREADY(d1_wready),
        .M_AXI_BRESP(d1_bresp), .M_AXI_BVALID(d1_bvalid), .M_AXI_BREADY(d1_bready),
        .M_AXI_ARID(d1_arid), .M_AXI_ARADDR(d1_araddr), .M_AXI_ARLEN(d1_arlen),
        .M_AXI_ARSIZE(d1_arsize), .M_AXI_ARBURST(d1_arburst), .M_AXI_ARLOCK(d1_arlock),
        .M_AXI_ARCACHE(d1_arcache), .M_AXI_ARPROT(d1_arprot), .M_AXI_ARQOS(d1_arqos),
        .M_AXI_ARVALID(d1_arvalid), .M_AXI_ARREADY(d1_arready),
        .M_AXI_RDATA(d1_rdata), .M_AXI_RRESP(d1_rresp), .M_AXI_RLAST(d1_rlast),
        .M_AXI_RVALID(d1_rvalid), .M_AXI_RREADY(d1_rready)
    );

    // Scenario knobs, written only by the main sequence.
    bit          bp;
    logic [3:0]  bad_b;
    logic [31:0] corrupt_mask;

    // Slave 0 state and logs, written only by the slave process.
    logic [31:0] mem [0:63];
    logic [31:0] aw_log[$], ar_log[$], wd_log[$];
    int          wlast_err = 0, stall_viol = 0;
    int          wbeat, rbeat, rlen;
    logic [31:0] waddr, raddr, p_awaddr, p_wdata;
    bit          b_pend, b_hs, r_hs, r_act, p_aw_stall, p_w_stall;

    // Handshakes are decided at the negedge: both sides are stable until the next posedge.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
                b_pend = 0; b_hs = 0; r_hs = 0; r_act = 0; wbeat = 0;
                p_aw_stall = 0; p_w_stall = 0;
                continue;
            end
            if (p_aw_stall && (awvalid !== 1'b1 || awaddr !== p_awaddr)) stall_viol++;
            if (p_w_stall && (wvalid !== 1'b1 || wdata !== p_wdata)) stall_viol++;
            if (b_hs) bvalid = 0;
            if (r_hs) begin
                rvalid = 0;
                rbeat++;
                if (rbeat == rlen) r_act = 0;
            end
            awready = !bp || ($urandom % 2 == 0);
            wready  = !bp || ($urandom % 2 == 0);
            arready = !bp || ($urandom % 2 == 0);
            if (b_pend && !bvalid) begin
                bvalid = 1;
                bresp  = bad_b[(waddr >> 5) & 32'h3] ? 2'b10 : 2'b00;
                b_pend = 0;
            end
            if (r_act && !rvalid && (!bp || $urandom % 2 == 0)) begin
                rvalid = 1;
                rdata  = mem[(raddr >> 2) + 32'(rbeat)];
                rresp  = 2'b00;
                rlast  = (rbeat == rlen - 1);
            end
            b_hs = bvalid && bready;
            r_hs = rvalid && rready;
            if (awvalid && awready) begin
                aw_log.push_back(awaddr);
                waddr = awaddr;
                wbeat = 0;
            end
            if (wvalid && wready) begin
                mem[(waddr >> 2) + 32'(wbeat)] = wdata;
                wd_log.push_back(wdata);
                if (wlast !== (wbeat == BL - 1)) wlast_err++;
                wbeat++;
                if (wbeat == BL) b_pend = 1;
            end
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                raddr = araddr;
                rbeat = 0;
                rlen  = int'(arlen) + 1;
                r_act = 1;
                // Backdoor corruption lands before the first beat is read back.
                if (araddr == 32'h0)
                    for (int i = 0; i < 32; i++) if (corrupt_mask[i]) mem[i] ^= 32'h0000_00A5;
            end
            p_aw_stall = awvalid && !awready;
            p_awaddr   = awaddr;
            p_w_stall  = wvalid && !wready;
            p_wdata    = wdata;
        end
    end

    // Slave 1: always ready, single 64-bit word.
    logic [63:0] d1_mem = 64'h0;
    int          d1_wcount = 0;
    logic        d1_wlast_seen = 1'b0;
    bit          d1_bpend, d1_rpend, d1_bhs, d1_rhs;
    initial begin
        d1_awready = 1; d1_wready = 1; d1_arready = 1; d1_bvalid = 0; d1_bresp = 0;
        d1_rvalid = 0; d1_rdata = 0; d1_rresp = 0; d1_rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                d1_bvalid = 0; d1_rvalid = 0; d1_bpend = 0; d1_rpend = 0;
                d1_bhs = 0; d1_rhs = 0;
                continue;
            end
            if (d1_bhs) d1_bvalid = 0;
            if (d1_rhs) d1_rvalid = 0;
            if (d1_bpend && !d1_bvalid) begin d1_bvalid = 1; d1_bpend = 0; end
            if (d1_rpend && !d1_rvalid) begin
                d1_rvalid = 1; d1_rdata = d1_mem; d1_rlast = 1; d1_rpend = 0;
            end
            d1_bhs = d1_bvalid && d1_bready;
            d1_rhs = d1_rvalid && d1_rready;
            if (d1_wvalid) begin
                d1_mem = d1_wdata; d1_wcount++; d1_wlast_seen = d1_wlast; d1_bpend = 1;
            end
            if (d1_arvalid) d1_rpend = 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_init(input bit sel);
        if (sel) d1_init = 1'b1; else init0 = 1'b1;
        repeat (2) @(negedge clk);
        d1_init = 1'b0;
        init0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input bit sel, input int budget);
        int n = 0;
        while ((sel ? d1_done : done0) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel ? d1_done : done0, 1);
    endtask

    // Expected results come from the address/pattern rules and the injected faults.
    task automatic run_pass(input string tag, input bit bpv, input logic [3:0] badb,
                            input logic [31:0] cmask);
        int aw0, ar0, wd0, wl0, sv0, exp_err;
        bp = bpv; bad_b = badb; corrupt_mask = cmask;
        aw0 = aw_log.size(); ar0 = ar_log.size(); wd0 = wd_log.size();
        wl0 = wlast_err; sv0 = stall_viol;
        pulse_init(0);
        check({tag, "_done_clr"}, done0, 0);
        wait_done({tag, "_done"}, 0, 4000);
        exp_err = $countones(badb) + $countones(cmask);
        check({tag, "_errcnt"}, errc0, exp_err);
        check({tag, "_error"}, error0, exp_err != 0);
        check({tag, "_naw"}, aw_log.size() - aw0, NB);
        check({tag, "_nar"}, ar_log.size() - ar0, NB);
        check({tag, "_nw"}, wd_log.size() - wd0, NBEATS);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("%s_awaddr%0d", tag, k),
                  (aw0 + k < aw_log.size()) ? aw_log[aw0 + k] : 32'hDEAD_BEEF, k * BL * 4);
            check($sformatf("%s_araddr%0d", tag, k),
                  (ar0 + k < ar_log.size()) ? ar_log[ar0 + k] : 32'hDEAD_BEEF, k * BL * 4);
        end
        for (int k = 0; k < NBEATS; k++)
            check($sformatf("%s_wdata%0d", tag, k),
                  (wd0 + k < wd_log.size()) ? wd_log[wd0 + k] : 32'hDEAD_BEEF, k + 1);
        check({tag, "_wlast"}, wlast_err - wl0, 0);
        check({tag, "_stable"}, stall_viol - sv0, 0);
    endtask

    initial begin
        int n;
        init0 = 0; d1_init = 0; bp = 0; bad_b = 0; corrupt_mask = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_outs0", {awvalid, wvalid, bready, arvalid, rready, done0, error0, errc0}, 0);
        check("rst_outs1", {d1_awvalid, d1_wvalid, d1_bready, d1_arvalid, d1_rready, d1_done,
                            d1_error, d1_errc}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("awlen", awlen, 7);
        check("awsize", {awsize, arsize}, {3'd2, 3'd2});
        check("burst_cache", {awburst, awcache, arburst, arcache}, {2'b01, 4'b0011, 2'b01, 4'b0011});
        check("wstrb", {wstrb, d1_wstrb}, 12'hFFF);
        check("d1_size_len", {d1_awsize, d1_awlen}, {3'd3, 8'd0});

        run_pass("basic", 0, 4'b0000, 32'h0);
        run_pass("bresp", 0, 4'b0100, 32'h0);
        run_pass("corrupt", 0, 4'b0000, 32'h1 << 17);
        run_pass("bp", 1, 4'b0000, 32'h0);
        for (int it = 0; it < 3; it++)
            run_pass($sformatf("rand%0d", it), 1, 4'($urandom), $urandom & $urandom & $urandom);

        // Reset during the write data phase, then a clean pass.
        bp = 0; bad_b = 0; corrupt_mask = 0;
        n = wd_log.size();
        pulse_init(0);
        for (int i = 0; i < 200 && wd_log.size() < n + 3; i++) @(negedge clk);
        check("midrst_reached", wvalid, 1);
        rst_n = 0;
        #1;
        check("midrst_outs", {awvalid, wvalid, bready, arvalid, rready, done0, error0, errc0}, 0);
        repeat (3) @(negedge clk);
        check("midrst_hold", {awvalid, wvalid, bready, arvalid, rready, done0}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        run_pass("postrst", 0, 4'b0000, 32'h0);

        // Single-beat 64-bit instance, two passes.
        for (int p = 0; p < 2; p++) begin
            pulse_init(1);
            check($sformatf("d1_done_clr%0d", p), d1_done, 0);
            wait_done($sformatf("d1_done%0d", p), 1, 200);
            check($sformatf("d1_wcount%0d", p), d1_wcount, p + 1);
            check($sformatf("d1_wlast%0d", p), d1_wlast_seen, 1);
            check($sformatf("d1_data%0d", p), d1_mem, 64'h1);
            check($sformatf("d1_err%0d", p), {d1_error, d1_errc}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
